branch_pred_ctrl: RTL and testbench

Parametrised successor to the pipeline controller's PC-source logic. Resolves every RV32I control transfer in EX (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR), using signed and unsigned compare flags rather than a negative flag. Adds a bimodal branch-history table (BHT) that predicts in IF. Drives misprediction redirect/flush, runs a post-redirect recovery FSM, and keeps saturating branch/mispredict statistics.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/bht_bimodal.sv | 39 +++
 rtl/branch_pred_ctrl.sv | 164 ++++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the EX-stage control-transfer resolver and its branch predictor.
package pipe_ctrl_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_PRED   = 2'b01;
  localparam logic [1:0] PCSRC_EX_TGT = 2'b10;
  localparam logic [1:0] PCSRC_EX_SEQ = 2'b11;

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_RECOVER = 1'b1
  } rec_state_e;

  // Two-bit saturating counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11)) nxt = ctr + 2'(1);
    if (!taken && (ctr != 2'b00)) nxt = ctr - 2'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/bht_bimodal.sv
// Bimodal branch-history table: 2-bit counters, one combinational read, one saturating update.
module bht_bimodal
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  // Read returns the pre-update value; a same-cycle write is not bypassed.
  assign rd_ctr_c = ctr_q[rd_idx];

  // Next-state of the counter array: only the addressed entry moves.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_INIT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// PC-source controller: resolves RV32I control transfers in EX, predicts in IF,
// redirects/flushes on mispredict, suppresses prediction after a redirect, keeps stats.
module branch_pred_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BHT_ENTRIES    = 64,
  parameter logic [1:0]  CTR_INIT       = 2'b01,
  parameter int unsigned PREDICT_MODE   = 1,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic             ex_ltu,
  output logic [1:0]       pc_src,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W   = $clog2(BHT_ENTRIES);
  localparam int unsigned REC_W   = $clog2(RECOVER_CYCLES + 1);
  localparam logic        PRED_EN = (PREDICT_MODE == 32'd1);

  rec_state_e       state_q, state_d;
  logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic       res_c, is_br_c, is_jal_c, is_jalr_c;
  logic       act_c, br_illegal_c;
  logic       redir_tgt_c, redir_seq_c, redirect_c;
  logic       bht_upd_c;
  logic [1:0] rd_ctr_c;
  logic       unused_pc;

  assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign res_c     = ex_valid && !ex_stall;
  assign is_br_c   = (ex_opcode == OPC_BRANCH);
  assign is_jal_c  = (ex_opcode == OPC_JAL);
  assign is_jalr_c = (ex_opcode == OPC_JALR);

  // Actual outcome from the compare flags; funct3 010/011 is not a branch.
  always_comb begin
    act_c        = 1'b0;
    br_illegal_c = 1'b0;
    if (is_br_c) begin
      case (ex_funct3)
        F3_BEQ:  act_c = ex_zero;
        F3_BNE:  act_c = !ex_zero;
        F3_BLT:  act_c = ex_lt;
        F3_BGE:  act_c = !ex_lt;
        F3_BLTU: act_c = ex_ltu;
        F3_BGEU: act_c = !ex_ltu;
        default: br_illegal_c = 1'b1;
      endcase
    end else if (is_jal_c || is_jalr_c) begin
      act_c = 1'b1;
    end
  end

  // JALR target is never predicted, so it always redirects; wrong-way predictions redirect too.
  assign redir_tgt_c = res_c && (is_jalr_c || ((is_br_c || is_jal_c) && act_c && !ex_pred_taken));
  assign redir_seq_c = res_c && !act_c && ex_pred_taken;
  assign redirect_c  = redir_tgt_c || redir_seq_c;

  assign bht_upd_c = res_c && is_br_c && !br_illegal_c && PRED_EN;

  bht_bimodal #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_ctr_c  (rd_ctr_c),
    .upd_en    (bht_upd_c),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (act_c)
  );

  assign if_pred_taken = rd_ctr_c[1] && (state_q == ST_NORMAL) && PRED_EN;

  // PC select: EX redirect beats the IF prediction.
  always_comb begin
    pc_src = PCSRC_SEQ;
    if (redir_tgt_c)        pc_src = PCSRC_EX_TGT;
    else if (redir_seq_c)   pc_src = PCSRC_EX_SEQ;
    else if (if_pred_taken) pc_src = PCSRC_PRED;
  end

  assign flush_if_id    = redirect_c;
  assign flush_id_ex    = redirect_c;
  assign illegal_branch = res_c && br_illegal_c;

  // Recovery FSM next state: a redirect (re)loads the suppression window.
  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (redirect_c) begin
          state_d   = ST_RECOVER;
          rec_cnt_d = REC_W'(RECOVER_CYCLES);
        end
      end
      ST_RECOVER: begin
        if (redirect_c) begin
          rec_cnt_d = REC_W'(RECOVER_CYCLES);
        end else if (rec_cnt_q == REC_W'(1)) begin
          state_d   = ST_NORMAL;
          rec_cnt_d = '0;
        end else begin
          rec_cnt_d = rec_cnt_q - REC_W'(1);
        end
      end
      default: begin
        state_d   = ST_NORMAL;
        rec_cnt_d = '0;
      end
    endcase
  end

  // Saturating statistics next values.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (res_c && (is_br_c || is_jal_c || is_jalr_c) && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (redirect_c && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
  end

  // State and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_NORMAL;
      rec_cnt_q <= '0;
      br_cnt_q  <= '0;
      mp_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      br_cnt_q  <= br_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: directed scenarios then random traffic against a reference model.
module tb_branch_pred_ctrl;

  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;
  localparam logic [6:0] T_ALU  = 7'b0110011;
  localparam int         NENT   = 64;
  localparam int         RCYC   = 2;

  logic        clk, rst;
  logic [31:0] if_pc, ex_pc;
  logic        ex_valid, ex_stall, ex_pred_taken, ex_zero, ex_lt, ex_ltu;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  logic        if_pred_taken, flush_if_id, flush_id_ex, illegal_branch;
  logic [1:0]  pc_src;
  logic [15:0] branch_count, mispredict_count;

  logic        s_if_pred, s_fl1, s_fl2, s_ill;
  logic [1:0]  s_pc_src;
  logic [1:0]  s_bc, s_mc;

  int n_chk = 0;
  int n_fail = 0;

  int m_bht [NENT];
  int m_supp, m_bc, m_mc;

  branch_pred_ctrl u_dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .pc_src(pc_src), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .illegal_branch(illegal_branch), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_pred_ctrl #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(s_if_pred),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .pc_src(s_pc_src), .flush_if_id(s_fl1), .flush_id_ex(s_fl2),
    .illegal_branch(s_ill), .branch_count(s_bc), .mispredict_count(s_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] clip(input int v, input int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_bht[i] = 1;
    m_supp = 0;
    m_bc   = 0;
    m_mc   = 0;
  endtask

  // One cycle: drive at negedge, compare just after, advance model at posedge.
  task automatic step(input logic v, input logic s, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] pc, input logic pr, input logic z, input logic lt,
                      input logic ltu, input logic [31:0] ipc);
    logic res, br, ctl, act, ill, base, r_tgt, r_seq, e_pred;
    int   e_src, ei;
    @(negedge clk);
    ex_valid = v; ex_stall = s; ex_opcode = op; ex_funct3 = f3; ex_pc = pc;
    ex_pred_taken = pr; ex_zero = z; ex_lt = lt; ex_ltu = ltu; if_pc = ipc;
    #1;
    res  = v && !s;
    br   = (op == T_BR);
    ctl  = br || (op == T_JAL) || (op == T_JALR);
    ill  = br && (f3[2:1] == 2'b01);
    base = (f3[2:1] == 2'b00) ? z : (f3[2:1] == 2'b10) ? lt : ltu;
    act  = br ? (!ill && (base ^ f3[0])) : ((op == T_JAL) || (op == T_JALR));
    r_tgt = res && ((op == T_JALR) || (ctl && act && !pr));
    r_seq = res && !act && pr;
    ei = int'(ipc[7:2]);
    e_pred = (m_supp == 0) && (m_bht[ei] >= 2);
    e_src  = r_tgt ? 2 : r_seq ? 3 : e_pred ? 1 : 0;
    chk("if_pred_taken", 32'(if_pred_taken), 32'(e_pred));
    chk("pc_src", 32'(pc_src), 32'(e_src));
    chk("flush_if_id", 32'(flush_if_id), 32'(r_tgt || r_seq));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(r_tgt || r_seq));
    chk("illegal_branch", 32'(illegal_branch), 32'(res && ill));
    chk("branch_count", 32'(branch_count), clip(m_bc, 65535));
    chk("mispredict_count", 32'(mispredict_count), clip(m_mc, 65535));
    chk("sat_branch_count", 32'(s_bc), clip(m_bc, 3));
    chk("sat_mispredict_count", 32'(s_mc), clip(m_mc, 3));
    chk("sat_pc_src", 32'(s_pc_src), 32'(e_src));
    @(posedge clk);
    if (res && br && !ill) begin
      ei = int'(pc[7:2]);
      m_bht[ei] = act ? ((m_bht[ei] < 3) ? m_bht[ei] + 1 : 3) : ((m_bht[ei] > 0) ? m_bht[ei] - 1 : 0);
    end
    if (res && ctl) m_bc++;
    if (r_tgt || r_seq) begin
      m_mc++;
      m_supp = RCYC;
    end else if (m_supp > 0) begin
      m_supp--;
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, 1'b0, T_ALU, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, ipc);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    ex_valid = 1'b0; ex_stall = 1'b0; ex_opcode = T_ALU; ex_funct3 = 3'b000; ex_pc = 32'h0;
    ex_pred_taken = 1'b0; ex_zero = 1'b0; ex_lt = 1'b0; ex_ltu = 1'b0; if_pc = 32'h40;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_flush", 32'(flush_if_id | flush_id_ex), 32'd0);
    chk("rst_if_pred", 32'(if_pred_taken), 32'd0);
    chk("rst_branch_count", 32'(branch_count), 32'd0);
    chk("rst_mispredict_count", 32'(mispredict_count), 32'd0);
    chk("rst_sat_mispredict", 32'(s_mc), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] pc, ipc;
    logic [6:0]  op;
    int          sel;
    rst = 1'b1;
    model_reset();
    do_reset();

    // BEQ taken but predicted not-taken: target redirect, counter 01 -> 10
    step(1'b1, 1'b0, T_BR, 3'b000, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
    // two more taken BEQs saturate the counter, then a clear IF lookup predicts taken
    step(1'b1, 1'b0, T_BR, 3'b000, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
    step(1'b1, 1'b0, T_BR, 3'b000, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
    idle(32'h40);
    chk("bht_sat_pc_src", 32'(pc_src), 32'd1);
    // BLTU not taken but predicted taken: sequential redirect, then suppression window
    step(1'b1, 1'b0, T_BR, 3'b110, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
    chk("bltu_pc_src", 32'(pc_src), 32'd3);
    idle(32'h40);
    idle(32'h40);
    idle(32'h40);
    // stalled JALR must not act until the stall drops
    repeat (3) step(1'b1, 1'b1, T_JALR, 3'b000, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44);
    step(1'b1, 1'b0, T_JALR, 3'b000, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44);
    // illegal funct3, with and without a carried prediction
    step(1'b1, 1'b0, T_BR, 3'b010, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b0, T_BR, 3'b011, 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    // JAL correctly predicted taken, aliased ALU op predicted taken
    step(1'b1, 1'b0, T_JAL, 3'b000, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48);
    step(1'b1, 1'b0, T_ALU, 3'b000, 32'h4c, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    // reset in the middle of recovery with trained counters
    step(1'b1, 1'b0, T_JALR, 3'b000, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
    do_reset();
    idle(32'h40);
    // five back-to-back redirects saturate the narrow counter
    repeat (5) step(1'b1, 1'b0, T_JALR, 3'b000, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60);
    idle(32'h0);
    chk("sat_hold", 32'(s_mc), 32'd3);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      pc  = ($urandom() & 32'h0000_0F00) | (32'($urandom_range(0, 15)) << 2);
      ipc = ($urandom_range(0, 1) == 1) ? pc : (32'($urandom_range(0, 63)) << 2);
      sel = $urandom_range(0, 9);
      op  = (sel < 6) ? T_BR : (sel == 6) ? T_JAL : (sel == 7) ? T_JALR : T_ALU;
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20, op, 3'($urandom_range(0, 7)),
           pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ipc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
